// File: rtl/ieee754_pkg.sv
// Shared binary32 field widths, special encodings and the unpacked-operand type
// used by the ieee754 adder and its helpers.
package ieee754_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP_NEG_INF = 32'hFF800000;

  // exp is the raw biased field; eeff is the exponent the datapath aligns with
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [EXP_W-1:0]  eeff;
    logic [FRAC_W:0]   sig;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

endpackage

// File: rtl/ieee754_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module ieee754_lzc (
  input  logic [26:0] d_i,
  output logic [4:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o = 5'd27;
    for (int i = 0; i < 27; i++)
      if (d_i[i]) cnt_o = 5'(26 - i);
  end

endmodule

// File: rtl/ieee754_adder.sv
// Registered binary32 adder, round-to-nearest-even, one-cycle latency.
// IEEE754_ADDER_SUBNORMAL_EN enables gradual underflow; otherwise subnormals flush to zero.
module ieee754_adder
  import ieee754_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic        out_valid,
  output logic [31:0] out
);

  function automatic fp_unpacked_t unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign   = x[31];
    u.exp    = x[30:23];
    u.is_nan = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    u.is_inf = (x[30:23] == 8'hFF) && (x[22:0] == '0);
`ifdef IEEE754_ADDER_SUBNORMAL_EN
    u.eeff    = (x[30:23] == '0) ? 8'd1 : x[30:23];
    u.sig     = {x[30:23] != '0, x[22:0]};
    u.is_zero = (x[30:0] == '0);
`else
    u.eeff    = (x[30:23] == '0) ? 8'd1 : x[30:23];
    u.sig     = (x[30:23] == '0) ? 24'd0 : {1'b1, x[22:0]};
    u.is_zero = (x[30:23] == '0);
`endif
    return u;
  endfunction

  fp_unpacked_t op1, op2, fa, fb;
  logic              swap, eff_sub;
  logic [7:0]        ediff, sh;
  logic [51:0]       shf;
  logic [26:0]       a_al, b_al, diff, m;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] exp_n, exp_r;
  logic              rup;
  logic [24:0]       rnd;
  logic [23:0]       mant;
  logic [31:0]       res_d, out_q;
  logic              vld_q;

  assign op1  = unpack(input1);
  assign op2  = unpack(input2);
  assign swap = {op2.exp, op2.sig[22:0]} > {op1.exp, op1.sig[22:0]};
  assign fa   = swap ? op2 : op1;
  assign fb   = swap ? op1 : op2;

  // Align B under A: 24-bit significand plus guard/round, the rest ORs into sticky.
  assign ediff   = fa.eeff - fb.eeff;
  assign shf     = {fb.sig, 28'd0} >> ediff;
  assign b_al    = (ediff >= 8'd26) ? 27'd1 : {shf[51:26], |shf[25:0]};
  assign a_al    = {fa.sig, 3'b000};
  assign eff_sub = fa.sign ^ fb.sign;
  assign sum     = {1'b0, a_al} + {1'b0, b_al};
  assign diff    = a_al - b_al;

  ieee754_lzc u_lzc (.d_i(diff), .cnt_o(lz));

`ifdef IEEE754_ADDER_SUBNORMAL_EN
  // Never normalize below exponent 1; what remains is a subnormal significand.
  logic [7:0] emax;
  assign emax = fa.eeff - 8'd1;
  assign sh   = ({3'b000, lz} > emax) ? emax : {3'b000, lz};
`else
  assign sh   = {3'b000, lz};
`endif

  always_comb begin
    if (!eff_sub) begin
      if (sum[27]) begin
        m     = {sum[27:2], sum[1] | sum[0]};
        exp_n = $signed({2'b00, fa.eeff}) + 10'sd1;
      end else begin
        m     = sum[26:0];
        exp_n = $signed({2'b00, fa.eeff});
      end
    end else begin
      m     = diff << sh;
      exp_n = $signed({2'b00, fa.eeff}) - $signed({2'b00, sh});
    end
  end

  assign rup   = m[2] & (m[1] | m[0] | m[3]);
  assign rnd   = {1'b0, m[26:3]} + {24'd0, rup};
  assign mant  = rnd[24] ? rnd[24:1] : rnd[23:0];
  assign exp_r = rnd[24] ? exp_n + 10'sd1 : exp_n;

  // Overrides in increasing priority; NaN rules win over everything.
  always_comb begin
    res_d = {fa.sign, exp_r[7:0], mant[22:0]};
    if (exp_r >= 10'sd255) res_d = fa.sign ? FP_NEG_INF : FP_POS_INF;
`ifdef IEEE754_ADDER_SUBNORMAL_EN
    if (!mant[23]) res_d = {fa.sign, 8'h00, mant[22:0]};
`else
    if (exp_r <= 10'sd0) res_d = {fa.sign, 31'd0};
`endif
    if (eff_sub && diff == '0) res_d = 32'h0;
    if (fb.is_zero) res_d = {fa.sign, fa.exp, fa.sig[22:0]};
    if (op1.is_zero && op2.is_zero) res_d = {op1.sign & op2.sign, 31'd0};
    if (op2.is_inf) res_d = op2.sign ? FP_NEG_INF : FP_POS_INF;
    if (op1.is_inf) res_d = op1.sign ? FP_NEG_INF : FP_POS_INF;
    if (op1.is_nan || op2.is_nan || (op1.is_inf && op2.is_inf && (op1.sign ^ op2.sign)))
      res_d = FP_QNAN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 32'h0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) out_q <= res_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_ieee754_adder.sv
// Directed-vector bench for ieee754_adder; subnormal expectations follow
// IEEE754_ADDER_SUBNORMAL_EN.
module tb_ieee754_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] input1, input2;
  logic        out_valid;
  logic [31:0] out;
  int          nvec = 0;
  int          nerr = 0;

  ieee754_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .input1(input1), .input2(input2),
    .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then check result and valid 1ns after it.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(negedge clk);
    input1 = a; input2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    chk(tag, out, exp);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; input1 = '0; input2 = '0;
    #12;
    chk("reset_out", out, 32'h0);
    chk("reset_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;

    apply("add_10_6",    32'h41200000, 32'h40C00000, 32'h41800000);
    apply("add_7_6",     32'h40E00000, 32'h40C00000, 32'h41500000);
    apply("add_31_15",   32'h41F80000, 32'h41700000, 32'h42380000);
    apply("add_15_31",   32'h41700000, 32'h41F80000, 32'h42380000);
    apply("neg_add",     32'hC1200000, 32'hC0C00000, 32'hC1800000);
    apply("sub_10_4",    32'h41200000, 32'hC0800000, 32'h40C00000);
    apply("cancel",      32'h3F800000, 32'hBF800000, 32'h00000000);
    apply("add_127",     32'h42FE0000, 32'h42FE0000, 32'h437E0000);
    apply("sub_norm",    32'h3F800000, 32'hBF400000, 32'h3E800000);
    apply("sub_norm_n",  32'hBF800000, 32'h3F400000, 32'hBE800000);
    apply("add_zero",    32'h420C0000, 32'h00000000, 32'h420C0000);
    apply("zero_add",    32'h00000000, 32'hC20C0000, 32'hC20C0000);
    apply("nzero_nzero", 32'h80000000, 32'h80000000, 32'h80000000);
    apply("pzero_nzero", 32'h00000000, 32'h80000000, 32'h00000000);
    apply("tie_even",    32'h3F800000, 32'h33800000, 32'h3F800000);
    apply("tie_odd",     32'h3F800001, 32'h33800000, 32'h3F800002);
    apply("above_tie",   32'h3F800000, 32'h33800001, 32'h3F800001);
    apply("inf_minf",    32'h7F800000, 32'hFF800000, 32'h7FC00000);
    apply("one_minf",    32'h3F800000, 32'hFF800000, 32'hFF800000);
    apply("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7F800000);
    apply("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    apply("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    apply("nan_in2",     32'h3F800000, 32'hFF800001, 32'h7FC00000);
`ifdef IEEE754_ADDER_SUBNORMAL_EN
    apply("sub_sub",     32'h00000001, 32'h00000001, 32'h00000002);
    apply("underflow",   32'h00800001, 32'h80800000, 32'h00000001);
`else
    apply("sub_sub",     32'h00000001, 32'h00000001, 32'h00000000);
    apply("underflow",   32'h00800001, 32'h80800000, 32'h00000000);
`endif

    // Three back-to-back operands, then an idle edge that must hold out.
    apply("b2b_0", 32'h3F800000, 32'h3F800000, 32'h40000000);
    apply("b2b_1", 32'h40000000, 32'h3F800000, 32'h40400000);
    apply("b2b_2", 32'h40400000, 32'h3F800000, 32'h40800000);
    idle();
    @(posedge clk); #1;
    chk("idle_vld",  {31'd0, out_valid}, 32'd0);
    chk("idle_hold", out, 32'h40800000);

    // Asynchronous reset mid-cycle while a result is in flight.
    apply("pre_rst", 32'h41200000, 32'h40C00000, 32'h41800000);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_out", out, 32'h0);
    chk("rst_async_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("post_rst_out", out, 32'h0);
    apply("post_rst_add", 32'h40E00000, 32'h40C00000, 32'h41500000);
    idle();
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ieee754_adder.md
# ieee754_adder

Single-precision (binary32) IEEE 754 floating-point adder with round-to-nearest-even. Subtraction is performed by sending an operand with its sign bit flipped. The result is computed combinationally and registered, so it can sit directly on a clocked ALU result path.

## Interface
- No parameters. Format is fixed binary32: 1 sign bit, 8 exponent bits, 23 fraction bits, bias 127.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  operands are sampled on this edge.
- `input1`  in  32  operand A, binary32.
- `input2`  in  32  operand B, binary32.
- `out_valid`  out  1  `out` holds a new result.
- `out`  out  32  input1 + input2, binary32.

## Operation
- Unpack each operand into sign, exponent and significand. Normal operands get the hidden 1 restored.
- Swap the operands so that A has the larger magnitude. Compare exponent first, then fraction.
- Align: right-shift the smaller significand by the exponent difference. Keep guard and round bits. OR every bit shifted out into sticky.
- Shift amounts of 26 or more leave only sticky set.
- Equal signs: add magnitudes. A carry-out causes a 1-bit right shift, and the shifted-out bit joins sticky.
- Different signs: subtract smaller from larger. Normalize left using a leading-zero count.
- The exponent is decremented by the shift amount and clamped per the Configuration section.
- Rounding is round-to-nearest-even on guard, round and sticky.
- If rounding overflows the significand, renormalize and increment the exponent.
- Result sign equals the sign of the larger-magnitude operand.
- Exact cancellation gives +0 (0x00000000).
- (-0) + (-0) gives -0. (+0) + (-0) gives +0.
- Exponent ≥ 255 after rounding: output ±infinity (0x7F800000 or 0xFF800000).
- Special cases:
  - Any NaN operand: output canonical quiet NaN 0x7FC00000.
  - +inf + -inf: output 0x7FC00000.
  - inf + finite: output that inf.
  - x + 0: output x exactly, except for the signed-zero rules above.
- Exceptions produce no flags.

## Timing
- Latency is one cycle.
- On a rising edge with `in_valid`=1, `out` takes the result for the operands present before that edge, and `out_valid`=1.
- On an edge with `in_valid`=0, `out` holds its value and `out_valid`=0.
- Back-to-back operands every cycle are supported. Throughput is 1 per cycle.
- Reset values: `out`=0x00000000, `out_valid`=0. They apply immediately on `rst` assertion, independent of `clk`.
- Reset asserted mid-stream discards the in-flight result.
- The first valid result after `rst` deasserts needs a fresh `in_valid` edge.
- No other state is held.

## Configuration
- `IEEE754_ADDER_SUBNORMAL_EN` defined:
  - Subnormal inputs are used with an implicit 0 and effective exponent 1.
  - Results below the normal range are denormalized (gradual underflow) and rounded to nearest-even.
- `IEEE754_ADDER_SUBNORMAL_EN` undefined:
  - Subnormal inputs are flushed to zero, keeping their sign.
  - Results with biased exponent ≤ 0 are flushed to a zero carrying the result sign.

## Structure
- Shared package `ieee754_pkg` holds:
  - Field widths: `EXP_W`=8, `FRAC_W`=23.
  - `EXP_BIAS`=127.
  - `FP_QNAN`=32'h7FC00000, `FP_POS_INF`=32'h7F800000, `FP_NEG_INF`=32'hFF800000.
  - An unpacked-operand struct typedef.
- Sub-module `ieee754_lzc` is a 27-bit leading-zero counter used for normalization after subtraction.
- Everything else (align, add/sub, round, pack, output register) lives in `ieee754_adder`.

## Test plan
- Same-sign add:
  - 0x41200000 + 0x40C00000 (10+6) -> 0x41800000.
  - 0x40E00000 + 0x40C00000 -> 0x41500000.
  - 0x41F80000 + 0x41700000, then operands swapped -> 0x42380000 both times.
- Mixed sign and cancellation:
  - 0x41200000 + 0xC0800000 (10-4) -> 0x40C00000.
  - 0x3F800000 + 0xBF800000 -> 0x00000000.
  - 0x42FE0000 + 0x42FE0000 -> 0x437E0000.
- Zero and rounding:
  - 0x420C0000 + 0x00000000 -> 0x420C0000.
  - 0x3F800000 + 0x33800000 (1 + 2^-24, tie case) -> 0x3F800000 (ties-to-even).
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Timing and reset:
  - Assert `rst` mid-stream -> `out`=0 and `out_valid`=0 immediately.
  - Drive `in_valid` for 3 consecutive cycles -> 3 consecutive `out_valid` pulses, each one cycle after its operands.
- Subnormal:
  - 0x00000001 + 0x00000001 -> 0x00000002 with the macro defined.
  - Same operands -> 0x00000000 with the macro undefined.
